// File: rtl/dmem_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : dmem_ctrl_pkg                                          |
// | Description : Shared types and constants for the data-memory access  |
// |               controller (state encoding, requester ids, widths).    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package dmem_ctrl_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 4;

  // Requester identifiers used for the latched winner
  localparam logic REQ_P = 1'b0;
  localparam logic REQ_S = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Word accesses only: any set low address bit is a misaligned request
  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_rr_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : dmem_rr_arb                                            |
// | Description : Pipeline-priority arbiter with starvation escape for   |
// |               the secondary master. Owns the starvation counter.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module dmem_rr_arb
  import dmem_ctrl_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic idle_i,
  input  logic p_req_i,
  input  logic s_req_i,
  output logic grant_o,
  output logic win_o
);

  localparam logic [CNT_W-1:0] c_limit = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_q;
  logic [CNT_W-1:0] starve_d;
  logic             w_starved;

  // Winner select: P by default, S when alone or after too many losses
  always_comb begin
    w_starved = s_req_i & (starve_q == c_limit);
    grant_o   = idle_i & (p_req_i | s_req_i);
    win_o     = (s_req_i & (~p_req_i | w_starved)) ? REQ_S : REQ_P;
    starve_d  = starve_q;
    if (idle_i) begin
      if (!s_req_i || win_o == REQ_S) begin
        starve_d = '0;
      end else if (starve_q != c_limit) begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  // Starvation counter only moves while the controller is arbitrating
  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : dmem_access_ctrl                                       |
// | Description : Sequences the single-port data memory shared by the    |
// |               MEM stage (P) and a secondary master (S); multi-cycle  |
// |               access with a combinational stall for the pipeline.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module dmem_access_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int MEM_LAT      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p_req,
  input  logic              p_we,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic              p_done,
  output logic [DATA_W-1:0] p_rdata,
  output logic              p_err,
  output logic              mem_stall,
  input  logic              s_req,
  input  logic              s_we,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_wdata,
  output logic              s_done,
  output logic [DATA_W-1:0] s_rdata,
  output logic              s_err,
  output logic              m_rd_en,
  output logic              m_wr_en,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam logic [CNT_W-1:0] c_lat_init = CNT_W'(MEM_LAT - 1);

  state_e            state_q;
  logic              win_q;
  logic [CNT_W-1:0]  lat_q;
  logic              p_done_q, s_done_q, p_err_q, s_err_q;
  logic [DATA_W-1:0] p_rdata_q, s_rdata_q;
  logic              m_rd_en_q, m_wr_en_q;
  logic [ADDR_W-1:0] m_addr_q;
  logic [DATA_W-1:0] m_wdata_q;

  logic              w_grant;
  logic              w_win;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_misal;

  dmem_rr_arb #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arb (
    .clk    (clk),
    .reset  (reset),
    .idle_i (state_q == IDLE),
    .p_req_i(p_req),
    .s_req_i(s_req),
    .grant_o(w_grant),
    .win_o  (w_win)
  );

  // Route the winning requester's command into the grant logic
  always_comb begin
    w_sel_we    = (w_win == REQ_S) ? s_we    : p_we;
    w_sel_addr  = (w_win == REQ_S) ? s_addr  : p_addr;
    w_sel_wdata = (w_win == REQ_S) ? s_wdata : p_wdata;
    w_misal     = is_misaligned(w_sel_addr[1:0]);
  end

  // Access sequencer: grant, hold enables for MEM_LAT cycles, pulse done
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      win_q     <= REQ_P;
      lat_q     <= '0;
      p_done_q  <= 1'b0;
      s_done_q  <= 1'b0;
      p_err_q   <= 1'b0;
      s_err_q   <= 1'b0;
      p_rdata_q <= '0;
      s_rdata_q <= '0;
      m_rd_en_q <= 1'b0;
      m_wr_en_q <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
    end else begin
      // done/err are single-cycle pulses
      p_done_q <= 1'b0;
      s_done_q <= 1'b0;
      p_err_q  <= 1'b0;
      s_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (w_grant) begin
            win_q <= w_win;
            if (w_misal) begin
              // No memory cycle: report the error right away
              state_q <= DONE;
              if (w_win == REQ_S) begin
                s_done_q <= 1'b1;
                s_err_q  <= 1'b1;
              end else begin
                p_done_q <= 1'b1;
                p_err_q  <= 1'b1;
              end
            end else begin
              state_q   <= BUSY;
              lat_q     <= c_lat_init;
              m_rd_en_q <= ~w_sel_we;
              m_wr_en_q <= w_sel_we;
              m_addr_q  <= w_sel_addr;
              m_wdata_q <= w_sel_wdata;
            end
          end
        end
        BUSY: begin
          if (lat_q == '0) begin
            state_q   <= DONE;
            m_rd_en_q <= 1'b0;
            m_wr_en_q <= 1'b0;
            if (win_q == REQ_S) begin
              s_done_q <= 1'b1;
              if (m_rd_en_q) s_rdata_q <= m_rdata;
            end else begin
              p_done_q <= 1'b1;
              if (m_rd_en_q) p_rdata_q <= m_rdata;
            end
          end else begin
            lat_q <= lat_q - 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign p_done    = p_done_q;
  assign s_done    = s_done_q;
  assign p_err     = p_err_q;
  assign s_err     = s_err_q;
  assign p_rdata   = p_rdata_q;
  assign s_rdata   = s_rdata_q;
  assign m_rd_en   = m_rd_en_q;
  assign m_wr_en   = m_wr_en_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign mem_stall = p_req & ~p_done_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_dmem_access_ctrl                                    |
// | Description : Directed self-checking bench for dmem_access_ctrl with |
// |               a small behavioural memory behind the m_* port.        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        p_req, p_we, s_req, s_we;
  logic [31:0] p_addr, p_wdata, s_addr, s_wdata;
  logic        p_done, p_err, mem_stall, s_done, s_err;
  logic [31:0] p_rdata, s_rdata;
  logic        m_rd_en, m_wr_en;
  logic [31:0] m_addr, m_wdata, m_rdata;

  logic [31:0] mem [0:63];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.MEM_LAT(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_done(p_done), .p_rdata(p_rdata), .p_err(p_err), .mem_stall(mem_stall),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_done(s_done), .s_rdata(s_rdata), .s_err(s_err),
    .m_rd_en(m_rd_en), .m_wr_en(m_wr_en), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata)
  );

  // Memory model: preloaded while reset is low, written on m_wr_en
  assign m_rdata = mem[m_addr[7:2]];
  always @(posedge clk) begin
    if (!reset) begin
      mem[4]  <= 32'hDEADBEEF;
      mem[8]  <= 32'h0;
      mem[12] <= 32'hA5A50F0F;
    end else if (m_wr_en) begin
      mem[m_addr[7:2]] <= m_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int p_at, s_at, nd;
    logic [9:0] seq;
    logic p_seen;

    reset = 1'b0;
    p_req = 0; p_we = 0; p_addr = 0; p_wdata = 0;
    s_req = 0; s_we = 0; s_addr = 0; s_wdata = 0;
    repeat (3) step();

    // Reset state
    chk("rst_done", {30'd0, p_done, s_done}, 32'd0);
    chk("rst_err", {30'd0, p_err, s_err}, 32'd0);
    chk("rst_en", {30'd0, m_rd_en, m_wr_en}, 32'd0);
    chk("rst_maddr", m_addr, 32'd0);
    chk("rst_mwdata", m_wdata, 32'd0);
    chk("rst_prdata", p_rdata, 32'd0);
    chk("rst_srdata", s_rdata, 32'd0);
    reset = 1'b1;
    step();

    // P read at 0x10
    p_req = 1; p_we = 0; p_addr = 32'h10; #1;
    chk("prd_stall_t0", {31'd0, mem_stall}, 32'd1);
    step();
    chk("prd_rden_t1", {31'd0, m_rd_en}, 32'd1);
    chk("prd_maddr_t1", m_addr, 32'h10);
    chk("prd_stall_t1", {31'd0, mem_stall}, 32'd1);
    step();
    chk("prd_rden_t2", {31'd0, m_rd_en}, 32'd1);
    chk("prd_done_t2", {31'd0, p_done}, 32'd0);
    chk("prd_stall_t2", {31'd0, mem_stall}, 32'd1);
    step();
    chk("prd_done_t3", {31'd0, p_done}, 32'd1);
    chk("prd_rdata_t3", p_rdata, 32'hDEADBEEF);
    chk("prd_rden_t3", {31'd0, m_rd_en}, 32'd0);
    chk("prd_stall_t3", {31'd0, mem_stall}, 32'd0);
    chk("prd_err_t3", {31'd0, p_err}, 32'd0);
    p_req = 0;
    step();
    chk("prd_done_t4", {31'd0, p_done}, 32'd0);

    // S read at 0x30 then S write 0x12345678 to 0x20
    s_req = 1; s_we = 0; s_addr = 32'h30;
    repeat (3) step();
    chk("srd_done", {31'd0, s_done}, 32'd1);
    chk("srd_rdata", s_rdata, 32'hA5A50F0F);
    s_req = 0;
    step();
    s_req = 1; s_we = 1; s_addr = 32'h20; s_wdata = 32'h12345678;
    step();
    chk("swr_wren_t1", {30'd0, m_wr_en, m_rd_en}, 32'd2);
    chk("swr_maddr", m_addr, 32'h20);
    chk("swr_mwdata", m_wdata, 32'h12345678);
    step();
    chk("swr_wren_t2", {31'd0, m_wr_en}, 32'd1);
    chk("swr_done_t2", {31'd0, s_done}, 32'd0);
    step();
    chk("swr_done_t3", {31'd0, s_done}, 32'd1);
    chk("swr_wren_t3", {31'd0, m_wr_en}, 32'd0);
    chk("swr_srdata_kept", s_rdata, 32'hA5A50F0F);
    chk("swr_err", {31'd0, s_err}, 32'd0);
    s_req = 0;
    step();
    chk("swr_done_t4", {31'd0, s_done}, 32'd0);
    chk("swr_mem", mem[8], 32'h12345678);

    // Misaligned P read at 0x13
    p_req = 1; p_we = 0; p_addr = 32'h13;
    step();
    chk("mis_done", {31'd0, p_done}, 32'd1);
    chk("mis_err", {31'd0, p_err}, 32'd1);
    chk("mis_rden", {31'd0, m_rd_en}, 32'd0);
    chk("mis_rdata_kept", p_rdata, 32'hDEADBEEF);
    p_req = 0;
    step();
    chk("mis_done_t2", {30'd0, p_done, p_err}, 32'd0);
    chk("mis_rden_t2", {31'd0, m_rd_en}, 32'd0);

    // Simultaneous P and S with count 0: P first, S in the next IDLE
    p_req = 1; p_we = 0; p_addr = 32'h10;
    s_req = 1; s_we = 0; s_addr = 32'h30;
    p_at = 0; s_at = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (p_done && p_at == 0) begin p_at = c; p_req = 0; end
      if (s_done && s_at == 0) begin s_at = c; s_req = 0; end
      if (p_at != 0 && s_at != 0) break;
    end
    chk("sim_p_cycle", p_at, 32'd3);
    chk("sim_s_cycle", s_at, 32'd7);
    step();

    // Both held: expect P,P,P,P,S,P,P,P,P,S (1 = S)
    p_req = 1; s_req = 1;
    seq = '0; nd = 0;
    for (int c = 0; c < 100 && nd < 10; c++) begin
      step();
      if (p_done || s_done) begin
        seq = {seq[8:0], s_done};
        nd++;
      end
    end
    p_req = 0; s_req = 0;
    chk("starve_count", nd, 32'd10);
    chk("starve_order", {22'd0, seq}, 32'h021);
    step(); step();

    // Reset in the middle of a P read
    p_req = 1; p_we = 0; p_addr = 32'h10;
    step();
    chk("rstb_rden", {31'd0, m_rd_en}, 32'd1);
    reset = 1'b0;
    step();
    chk("rstb_rden_off", {31'd0, m_rd_en}, 32'd0);
    chk("rstb_pdone", {31'd0, p_done}, 32'd0);
    chk("rstb_prdata", p_rdata, 32'd0);
    reset = 1'b1; p_req = 0;
    s_req = 1; s_we = 0; s_addr = 32'h30;
    p_seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (p_done) p_seen = 1'b1;
    end
    chk("rstb_idle_sdone", {31'd0, s_done}, 32'd1);
    chk("rstb_idle_srdata", s_rdata, 32'hA5A50F0F);
    chk("rstb_no_pdone", {31'd0, p_seen}, 32'd0);
    s_req = 0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences and arbitrates the single-port data memory used by the MEM stage.
- Two requesters share it: the pipeline MEM stage (port P) and a secondary master such as debug or DMA (port S).
- Models a multi-cycle memory access of MEM_LAT cycles.
- Produces the stall the pipeline uses to deassert the MEM/WB stage-register enable (EN_REG) until its access completes.

Parameters:
- MEM_LAT, 2, cycles the memory enables are held per access; legal 1..15.
- STARVE_LIMIT, 4, consecutive lost arbitrations after which S wins the next one; legal 1..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low (0 = reset).
- p_req  in  1  pipeline access request.
- p_we  in  1  pipeline write (1) / read (0).
- p_addr  in  32  pipeline byte address.
- p_wdata  in  32  pipeline write data.
- p_done  out  1  pipeline access complete, one-cycle pulse.
- p_rdata  out  32  pipeline read data, valid with p_done.
- p_err  out  1  pipeline misaligned-address error, valid with p_done.
- mem_stall  out  1  = p_req & ~p_done, combinational; pipeline holds EN_REG low while 1.
- s_req  in  1  secondary request.
- s_we  in  1  secondary write / read.
- s_addr  in  32  secondary byte address.
- s_wdata  in  32  secondary write data.
- s_done  out  1  secondary access complete, one-cycle pulse.
- s_rdata  out  32  secondary read data.
- s_err  out  1  secondary misaligned error.
- m_rd_en  out  1  memory read enable.
- m_wr_en  out  1  memory write enable.
- m_addr  out  32  memory address.
- m_wdata  out  32  memory write data.
- m_rdata  in  32  memory read data, combinational from m_addr.

Behaviour:
- Reset (reset==0 at a rising edge):
  - State returns to IDLE; starvation count clears to 0.
  - All outputs clear to 0: done, err, rdata, and m_* enables, address and data.
  - Reset during an active access aborts it: enables drop and no done pulse is issued.
- States:
  - IDLE -> BUSY on a granted aligned request.
  - IDLE -> DONE on a granted misaligned request (addr[1:0]!=0).
  - BUSY -> DONE when the latency count reaches 0.
  - DONE -> IDLE unconditionally.
- Arbitration (IDLE only):
  - P wins when p_req=1, unless s_req=1 and the starvation count == STARVE_LIMIT.
  - S wins when it is the only requester or is starved.
  - On grant, the winner id, we, addr and wdata are latched; requester inputs are ignored until that requester's done.
- Starvation count:
  - +1 at each grant to P while s_req=1, saturating at STARVE_LIMIT.
  - Clears to 0 on a grant to S, or in any IDLE cycle with s_req=0.
- BUSY:
  - m_addr/m_wdata are driven from the latched values.
  - m_rd_en = ~we, m_wr_en = we; exactly one is high, for exactly MEM_LAT cycles.
  - A down-counter is loaded with MEM_LAT-1 at grant.
  - For reads, m_rdata is captured on the last BUSY cycle into the winner's rdata register.
- DONE:
  - The winner's done pulses high for one cycle; err=1 only for a misaligned access.
  - m_* enables are 0.
  - rdata registers hold their value until the next read by that requester; writes and errors leave them unchanged. A misaligned request issues no memory access.
- Latency: a request granted at edge t gives done high in cycle t+MEM_LAT+1 (aligned) or t+1 (misaligned). A new grant is possible at the edge ending the cycle after DONE.
- Simultaneous requests: exactly one grant per IDLE cycle; the loser's request stays pending and is not lost.
- A request dropped before grant is ignored. A request dropped after grant still completes and pulses done.
- Memory enables are never high outside BUSY.

Decomposition:
- Package dmem_ctrl_pkg holds:
  - State enum (IDLE, BUSY, DONE).
  - Requester id constants (REQ_P=0, REQ_S=1).
  - Width constants: 32-bit data/addr, 4-bit counters.
- One sub-module, dmem_rr_arb: combinational winner select plus the starvation counter register.

Test Plan:
- Reset mid-BUSY: P read at 0x10, assert reset (0) during BUSY -> next cycle m_rd_en=0 and state IDLE; p_done never pulses.
- P read alone, MEM_LAT=2, mem[0x10]=0xDEADBEEF -> m_rd_en high 2 cycles; p_done at t+3 with p_rdata=0xDEADBEEF; mem_stall high t..t+2, low t+3.
- S write 0x12345678 to 0x20 -> m_wr_en high 2 cycles with m_addr=0x20; s_done once; s_rdata unchanged.
- P and S held continuously, STARVE_LIMIT=4 -> grant order P,P,P,P,S,P,P,P,P,S; count clears after each S grant.
- P read at 0x13 -> p_done and p_err at t+1; m_rd_en never asserted; p_rdata unchanged.
- P and S request in the same cycle, count 0 -> P served first; S served in the very next IDLE with no request lost.
